// File: rtl/omsp_spm_protect_seq.sv
// omsp_spm_protect_seq
//
// Purpose: sequences a protect/unprotect request from the execution unit into a
// single update_spm/enable_spm pulse for SPM control. After a successful
// protect, it fetches the module key from the key-derivation unit and streams
// it one 16-bit word per cycle into SPM control.
//
// Ports:
//   mclk, puc_rst           clock, asynchronous active-high reset
//   start_protect           one-cycle request to create an SPM
//   start_unprotect         one-cycle request to disable the calling SPM
//   violation               SPM control verdict, valid with update_spm
//   key_ack, key_data       key-derivation handshake and derived key (MSB first)
//   busy, done, error       status back to the execution unit
//   update_spm, enable_spm  update request to SPM control (1 = create)
//   key_req                 key request to key-derivation unit
//   write_key, key_in,
//   key_idx                 key word write port into SPM control
module omsp_spm_protect_seq #(
  parameter int unsigned SECURITY     = 64,
  parameter int unsigned KEY_IDX_SIZE = 2
) (
  input  logic                    mclk,
  input  logic                    puc_rst,
  input  logic                    start_protect,
  input  logic                    start_unprotect,
  input  logic                    violation,
  input  logic                    key_ack,
  input  logic [SECURITY-1:0]     key_data,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic                    update_spm,
  output logic                    enable_spm,
  output logic                    key_req,
  output logic                    write_key,
  output logic [15:0]             key_in,
  output logic [KEY_IDX_SIZE-1:0] key_idx
);

  localparam int unsigned WORDS = SECURITY / 16;
  localparam logic [KEY_IDX_SIZE-1:0] LastIdx = KEY_IDX_SIZE'(WORDS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StUpdP,
    StUpdU,
    StKeyWait,
    StKeyWrite,
    StDone
  } state_e;

  state_e                  r_state;
  logic [KEY_IDX_SIZE-1:0] r_idx;
  logic [SECURITY-1:0]     r_key;
  logic                    r_error;

  logic [SECURITY-1:0]     w_key_shifted;

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      r_state <= StIdle;
      r_idx   <= '0;
      r_key   <= '0;
      r_error <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          // Protect has priority; a simultaneous unprotect is dropped.
          if (start_protect) begin
            r_state <= StUpdP;
            r_error <= 1'b0;
          end else if (start_unprotect) begin
            r_state <= StUpdU;
            r_error <= 1'b0;
          end
        end
        StUpdP: begin
          // SPM control answers combinationally in the update cycle.
          if (violation) begin
            r_error <= 1'b1;
            r_state <= StDone;
          end else begin
            r_state <= StKeyWait;
          end
        end
        StUpdU: begin
          r_state <= StDone;
        end
        StKeyWait: begin
          if (key_ack) begin
            r_key   <= key_data;
            r_idx   <= '0;
            r_state <= StKeyWrite;
          end
        end
        StKeyWrite: begin
          if (r_idx == LastIdx) begin
            r_idx   <= '0;
            r_state <= StDone;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  // Key bit 0 is the MSB, so word N sits N words below the top of the vector.
  assign w_key_shifted = r_key << {r_idx, 4'b0000};

  always_comb begin
    busy       = (r_state != StIdle);
    done       = 1'b0;
    update_spm = 1'b0;
    enable_spm = 1'b0;
    key_req    = 1'b0;
    write_key  = 1'b0;
    key_in     = 16'h0000;
    key_idx    = '0;
    unique case (r_state)
      StUpdP: begin
        update_spm = 1'b1;
        enable_spm = 1'b1;
      end
      StUpdU: begin
        update_spm = 1'b1;
      end
      StKeyWait: begin
        key_req = 1'b1;
      end
      StKeyWrite: begin
        write_key = 1'b1;
        key_idx   = r_idx;
        key_in    = w_key_shifted[SECURITY-1 -: 16];
      end
      StDone: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Error is held between operations, not only shown with done.
  assign error = r_error;

endmodule

// File: doc/omsp_spm_protect_seq.md
Name: omsp_spm_protect_seq

Overview:
Sequencer directly upstream of the SPM control block. It turns a protect or unprotect request from the execution unit into the update_spm/enable_spm pulse that control consumes. On a successful protect, it fetches the new module's key from the key-derivation unit and streams it word by word into the key_in/key_idx/write_key port. It reports busy/done/error back to the execution unit, which stalls while busy.

Parameters:
SECURITY, 64, key width in bits; multiple of 16; equals the SECURITY define of the build.
KEY_IDX_SIZE, 2, width of key_idx; WORDS = SECURITY/16 must be <= 2**KEY_IDX_SIZE.

Ports:
mclk  in  1  system clock
puc_rst  in  1  asynchronous active-high reset
start_protect  in  1  single-cycle request to create an SPM; r12..r15 are held by the execution unit
start_unprotect  in  1  single-cycle request to disable the calling SPM
violation  in  1  combinational violation from SPM control, valid in the same cycle as update_spm
key_ack  in  1  key-derivation handshake: key_data valid
key_data  in  SECURITY  derived key, bit 0 = MSB, same ordering as key_out
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
error  out  1  outcome of the last operation; held until the next accepted start
update_spm  out  1  update request to SPM control
enable_spm  out  1  1 = create, 0 = disable; meaningful only with update_spm
key_req  out  1  key request to key-derivation unit
write_key  out  1  key word write strobe
key_in  out  16  key word
key_idx  out  KEY_IDX_SIZE  key word index

Behaviour:
- States: IDLE, UPD_P, UPD_U, KEY_WAIT, KEY_WRITE, DONE. All outputs are decoded from the state and the registered index/key.
- Reset (async, any state): state=IDLE; word index=0; key register=0; error=0. All outputs are 0.
- IDLE:
  - start_protect -> UPD_P.
  - else start_unprotect -> UPD_U.
  - Both high in the same cycle: protect wins, unprotect is dropped.
  - Starts are ignored (not queued) in every other state.
- Accepting a start clears error.
- UPD_P (1 cycle): update_spm=1, enable_spm=1. Sample violation in this cycle.
  - violation=1 -> error<=1, go to DONE (no key fetch).
  - violation=0 -> KEY_WAIT.
- UPD_U (1 cycle): update_spm=1, enable_spm=0 -> DONE. violation is not sampled; error stays 0.
- KEY_WAIT: key_req=1 until key_ack.
  - On the key_ack cycle: latch key_data, index<=0, go to KEY_WRITE.
  - key_ack outside KEY_WAIT is ignored.
  - Wait is unbounded; only reset aborts it.
- KEY_WRITE: write_key=1, key_idx=index, key_in=key[index*16 +: 16] (word 0 = key bits 0..15).
  - index increments every cycle.
  - When index==WORDS-1: go to DONE, index<=0.
- DONE (1 cycle): done=1, error reflects the outcome -> IDLE.
- Latency, protect with key_ack in the first KEY_WAIT cycle: start sampled in cycle 0; UPD_P in cycle 1; KEY_WAIT in cycle 2; writes in cycles 3..2+WORDS; done in cycle 3+WORDS (cycle 7 for SECURITY=64).
- Latency, unprotect: UPD_U in cycle 1, done in cycle 2.
- Reset mid-operation: remaining key writes are dropped, and no done pulse is produced. SPM control is reset by the same puc_rst.
- update_spm is high for exactly one cycle per accepted start. write_key is high for exactly WORDS cycles per successful protect and never otherwise.

Test Plan:
- Protect, no violation, key_ack=1 immediately with key_data=64'h0123_4567_89AB_CDEF -> update_spm/enable_spm in cycle 1; write_key in cycles 3-6 with (key_idx,key_in)=(0,0123),(1,4567),(2,89AB),(3,CDEF); done in cycle 7 with error=0.
- Protect with violation=1 in the UPD_P cycle -> key_req never asserted, write_key never asserted, done in cycle 2 with error=1; error stays 1 until the next start.
- Unprotect -> update_spm=1 with enable_spm=0 in cycle 1, done in cycle 2, error=0, no key_req.
- key_ack delayed 5 cycles; start_protect and start_unprotect pulsed while busy -> key_req held for 5 cycles, extra starts ignored, exactly one update_spm pulse, 4 key writes.
- start_protect and start_unprotect high together -> protect sequence only (enable_spm=1).
- puc_rst asserted during KEY_WRITE after 2 words -> all outputs 0 immediately, no further writes, no done; a subsequent protect works normally from key_idx=0.
